// File: rtl/phase_sequencer.sv
// N-phase intersection sequencer: demand-driven round-robin green/yellow/all-red
// cycling with per-phase max-green, gap-out, walk timing and a tick prescaler.
module phase_sequencer #(
   parameter int NUM_PHASES   = 4,
   parameter int CLK_PER_TICK = 1000,
   parameter int TIMER_W      = 7,
   parameter int MIN_GREEN    = 10,
   parameter int YELLOW_TIME  = 4,
   parameter int ALL_RED_TIME = 2,
   parameter int WALK_TIME    = 7,
   localparam int PH_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PHASES*TIMER_W-1:0]   max_green,
   input  logic [NUM_PHASES-1:0]           demand_in,
   input  logic [NUM_PHASES-1:0]           ped_req,
   output logic [NUM_PHASES-1:0]           green,
   output logic [NUM_PHASES-1:0]           yellow,
   output logic [NUM_PHASES-1:0]           red,
   output logic [NUM_PHASES-1:0]           walk,
   output logic [NUM_PHASES-1:0]           hand,
   output logic [PH_W-1:0]                 phase,
   output logic [TIMER_W-1:0]              countdown,
   output logic                            tick
);

   localparam int PRE_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
   localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(CLK_PER_TICK - 1);
   localparam logic [TIMER_W-1:0] ONE_T     = TIMER_W'(1);
   localparam logic [TIMER_W-1:0] YEL_T     = TIMER_W'(YELLOW_TIME);
   localparam logic [TIMER_W-1:0] AR_T      = TIMER_W'(ALL_RED_TIME);
   localparam logic [TIMER_W-1:0] MIN_G     = TIMER_W'(MIN_GREEN);
   localparam logic [TIMER_W-1:0] WALK_T    = TIMER_W'(WALK_TIME);

   typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALL_RED} state_t;

   state_t                  state_q, state_d;
   logic [PH_W-1:0]         phase_q, phase_d;
   logic [TIMER_W-1:0]      cd_q, cd_d;
   logic [TIMER_W-1:0]      elapsed_q, el_d;
   logic [NUM_PHASES-1:0]   dem_q, dem_d;
   logic [NUM_PHASES-1:0]   ped_q, ped_d;
   logic                    walk_act_q, walk_act_d;
   logic [PRE_W-1:0]        presc_q;

   logic [NUM_PHASES-1:0]   cur_oh;
   logic                    walk_on;
   logic                    other;
   logic                    gap;
   logic                    enter;
   logic [PH_W-1:0]         enter_ph;
   logic [TIMER_W-1:0]      el_inc;
   logic [TIMER_W-1:0]      mg_raw;

   // Round-robin search starting after cur and wrapping to cur itself; phase 0 when idle.
   function automatic logic [PH_W-1:0] pick_next(input logic [NUM_PHASES-1:0] lat,
                                                 input logic [PH_W-1:0] cur);
      logic [PH_W-1:0] sel;
      logic            found;
      int              idx;
      sel   = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_PHASES; i++) begin
         idx = int'(cur) + i;
         if (idx >= NUM_PHASES) idx -= NUM_PHASES;
         if (!found && lat[idx]) begin
            sel   = PH_W'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign tick    = (presc_q == PRE_LAST);
   assign cur_oh  = NUM_PHASES'(1) << phase_q;
   assign walk_on = (state_q == S_GREEN) && walk_act_q && (elapsed_q < WALK_T);
   assign other   = |(dem_q & ~cur_oh);
   assign el_inc  = (elapsed_q == '1) ? elapsed_q : elapsed_q + 1'b1;
   assign gap     = (el_inc >= MIN_G) && !demand_in[phase_q] && other && !walk_on;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      cd_d       = cd_q;
      el_d       = elapsed_q;
      walk_act_d = walk_act_q;
      dem_d      = dem_q | (demand_in & ~((state_q == S_GREEN) ? cur_oh : '0)) | ped_req;
      ped_d      = ped_q | ped_req;
      enter      = 1'b0;
      enter_ph   = phase_q;
      mg_raw     = '0;
      if (tick) begin
         case (state_q)
            S_GREEN: begin
               if (cd_q == ONE_T && !other) begin
                  enter = 1'b1;            // rest: re-serve the same phase
               end else if (cd_q == ONE_T || gap) begin
                  state_d    = S_YELLOW;
                  cd_d       = YEL_T;
                  walk_act_d = 1'b0;
               end else begin
                  cd_d = cd_q - 1'b1;
                  el_d = el_inc;
               end
            end
            S_YELLOW: begin
               if (cd_q == ONE_T) begin
                  state_d = S_ALL_RED;
                  cd_d    = AR_T;
               end else begin
                  cd_d = cd_q - 1'b1;
               end
            end
            S_ALL_RED: begin
               if (cd_q == ONE_T) begin
                  enter    = 1'b1;
                  enter_ph = pick_next(dem_q, phase_q);
                  state_d  = S_GREEN;
               end else begin
                  cd_d = cd_q - 1'b1;
               end
            end
            default: state_d = S_ALL_RED;
         endcase
      end
      // Green entry clears the phase's latches, overriding any same-cycle request.
      if (enter) begin
         mg_raw          = max_green[int'(enter_ph)*TIMER_W +: TIMER_W];
         phase_d         = enter_ph;
         cd_d            = (mg_raw == '0) ? ONE_T : mg_raw;
         el_d            = '0;
         walk_act_d      = ped_q[enter_ph];
         dem_d[enter_ph] = 1'b0;
         ped_d[enter_ph] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_ALL_RED;
         phase_q    <= PH_W'(NUM_PHASES - 1);
         cd_q       <= AR_T;
         elapsed_q  <= '0;
         dem_q      <= '0;
         ped_q      <= '0;
         walk_act_q <= 1'b0;
         presc_q    <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         cd_q       <= cd_d;
         elapsed_q  <= el_d;
         dem_q      <= dem_d;
         ped_q      <= ped_d;
         walk_act_q <= walk_act_d;
         presc_q    <= tick ? '0 : presc_q + 1'b1;
      end
   end

   always_comb begin
      green     = (state_q == S_GREEN)  ? cur_oh : '0;
      yellow    = (state_q == S_YELLOW) ? cur_oh : '0;
      red       = ~(green | yellow);
      walk      = walk_on ? cur_oh : '0;
      hand      = ~walk;
      phase     = phase_q;
      countdown = cd_q;
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: directed scenarios queue expected lamp/phase/countdown
// snapshots per tick; a monitor pops and compares them as the ticks occur.
module tb_phase_sequencer;

   localparam int N   = 4;
   localparam int TW  = 7;
   localparam int G   = 0;
   localparam int Y   = 1;
   localparam int AR  = 2;

   logic              clk;
   logic              reset;
   logic [N*TW-1:0]   max_green;
   logic [N-1:0]      demand_in;
   logic [N-1:0]      ped_req;
   logic [N-1:0]      green, yellow, red, walk, hand;
   logic [1:0]        phase;
   logic [TW-1:0]     countdown;
   logic              tick;

   phase_sequencer #(
      .NUM_PHASES(N), .CLK_PER_TICK(4), .TIMER_W(TW), .MIN_GREEN(3),
      .YELLOW_TIME(2), .ALL_RED_TIME(1), .WALK_TIME(2)
   ) dut (
      .clk(clk), .reset(reset), .max_green(max_green), .demand_in(demand_in),
      .ped_req(ped_req), .green(green), .yellow(yellow), .red(red), .walk(walk),
      .hand(hand), .phase(phase), .countdown(countdown), .tick(tick)
   );

   typedef struct {
      int          tk;
      logic [3:0]  g;
      logic [3:0]  y;
      logic [3:0]  w;
      logic [1:0]  ph;
      logic [6:0]  cd;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   k        = 0;
   int   tk       = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s tk=%0d actual=%0h expected=%0h", nm, t, act, exp);
      end
   endtask

   task automatic expect_at(input int t, input int st, input int ph, input int cd, input logic [3:0] w);
      exp_t e;
      e.tk = t;
      e.g  = (st == G) ? 4'(1 << ph) : 4'b0;
      e.y  = (st == Y) ? 4'(1 << ph) : 4'b0;
      e.w  = w;
      e.ph = 2'(ph);
      e.cd = 7'(cd);
      q.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      demand_in = '0;
      ped_req   = '0;
      cyc(2);
      reset     = 1'b0;
   endtask

   // Monitor: bench-side prescaler model, per-cycle invariants, and scoreboard pops on ticks.
   initial begin
      exp_t e;
      logic ok;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            k  = 0;
            tk = 0;
         end else begin
            k++;
            if (k % 4 == 0) tk++;
         end
         chk("tick", tk, 32'(tick), 32'(!reset && (k % 4 == 3)));
         ok = (red === ~(green | yellow)) && (hand === ~walk) && $onehot0(green | yellow)
              && ((walk & ~green) == 4'b0);
         chk("invariant", tk, 32'(ok), 32'd1);
         if ((reset || (k % 4 == 0)) && q.size() > 0) begin
            if (q[0].tk == tk) begin
               e = q.pop_front();
               chk("green",     tk, 32'(green),     32'(e.g));
               chk("yellow",    tk, 32'(yellow),    32'(e.y));
               chk("walk",      tk, 32'(walk),      32'(e.w));
               chk("phase",     tk, 32'(phase),     32'(e.ph));
               chk("countdown", tk, 32'(countdown), 32'(e.cd));
            end else if (!reset && q[0].tk < tk) begin
               e = q.pop_front();
               chk("missed_tick", tk, 32'(e.tk), 32'(tk));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog tk=%0d actual=timeout expected=finish", tk);
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      demand_in = '0;
      ped_req   = '0;
      max_green = {N{7'd5}};

      // No demand: recall to phase 0 and rest in green.
      expect_at(0, AR, 3, 1, 4'b0);
      expect_at(1, G, 0, 5, 4'b0);
      expect_at(5, G, 0, 1, 4'b0);
      expect_at(6, G, 0, 5, 4'b0);
      expect_at(11, G, 0, 5, 4'b0);
      expect_at(12, G, 0, 4, 4'b0);
      do_reset();
      cyc(50);

      // Max-out with own demand held, skip to phase 2, then gap-out of phase 2.
      expect_at(0, AR, 3, 1, 4'b0);
      expect_at(1, G, 0, 5, 4'b0);
      expect_at(5, G, 0, 1, 4'b0);
      expect_at(6, Y, 0, 2, 4'b0);
      expect_at(7, Y, 0, 1, 4'b0);
      expect_at(8, AR, 0, 1, 4'b0);
      expect_at(9, G, 2, 5, 4'b0);
      expect_at(11, G, 2, 3, 4'b0);
      expect_at(12, Y, 2, 2, 4'b0);
      do_reset();
      demand_in = 4'b0001;
      cyc(9);
      demand_in = 4'b0101;
      cyc(1);
      demand_in = 4'b0001;
      cyc(40);
      demand_in = 4'b0000;

      // Gap-out at elapsed 3.
      expect_at(0, AR, 3, 1, 4'b0);
      expect_at(1, G, 0, 5, 4'b0);
      expect_at(3, G, 0, 3, 4'b0);
      expect_at(4, Y, 0, 2, 4'b0);
      expect_at(5, Y, 0, 1, 4'b0);
      expect_at(6, AR, 0, 1, 4'b0);
      expect_at(7, G, 1, 5, 4'b0);
      do_reset();
      cyc(4);
      demand_in = 4'b0010;
      cyc(1);
      demand_in = 4'b0000;
      cyc(25);

      // Same setup with own demand held: max-out at 5.
      expect_at(0, AR, 3, 1, 4'b0);
      expect_at(1, G, 0, 5, 4'b0);
      expect_at(4, G, 0, 2, 4'b0);
      expect_at(5, G, 0, 1, 4'b0);
      expect_at(6, Y, 0, 2, 4'b0);
      do_reset();
      demand_in = 4'b0001;
      cyc(4);
      demand_in = 4'b0011;
      cyc(1);
      demand_in = 4'b0001;
      cyc(22);
      demand_in = 4'b0000;

      // Pedestrian service of phase 1 with walk for two ticks before yellow.
      expect_at(0, AR, 3, 1, 4'b0);
      expect_at(1, G, 0, 5, 4'b0);
      expect_at(4, Y, 0, 2, 4'b0);
      expect_at(6, AR, 0, 1, 4'b0);
      expect_at(7, G, 1, 5, 4'b0010);
      expect_at(8, G, 1, 4, 4'b0010);
      expect_at(9, G, 1, 3, 4'b0);
      expect_at(10, Y, 1, 2, 4'b0);
      do_reset();
      cyc(5);
      ped_req = 4'b0010;
      cyc(1);
      ped_req = 4'b0000;
      cyc(23);
      demand_in = 4'b0100;
      cyc(1);
      demand_in = 4'b0000;
      cyc(12);

      // Requests in the very cycle phase 3 enters green are cleared, not re-served.
      expect_at(0, AR, 3, 1, 4'b0);
      expect_at(1, G, 0, 5, 4'b0);
      expect_at(4, Y, 0, 2, 4'b0);
      expect_at(6, AR, 0, 1, 4'b0);
      expect_at(7, G, 3, 5, 4'b0);
      expect_at(10, Y, 3, 2, 4'b0);
      expect_at(12, AR, 3, 1, 4'b0);
      expect_at(13, G, 0, 5, 4'b0);
      expect_at(16, G, 0, 2, 4'b0);
      expect_at(18, G, 0, 5, 4'b0);
      do_reset();
      cyc(5);
      demand_in = 4'b1000;
      cyc(1);
      demand_in = 4'b0000;
      cyc(21);
      demand_in = 4'b1000;
      ped_req   = 4'b1000;
      cyc(1);
      demand_in = 4'b0000;
      ped_req   = 4'b0000;
      cyc(1);
      demand_in = 4'b0001;
      cyc(1);
      demand_in = 4'b0000;
      cyc(45);

      // Reset in the middle of phase 2 yellow drops latched demand and restarts at phase 0.
      expect_at(0, AR, 3, 1, 4'b0);
      expect_at(1, G, 0, 5, 4'b0);
      expect_at(4, Y, 0, 2, 4'b0);
      expect_at(7, G, 2, 5, 4'b0);
      expect_at(10, Y, 2, 2, 4'b0);
      expect_at(0, AR, 3, 1, 4'b0);
      expect_at(1, G, 0, 5, 4'b0);
      expect_at(2, G, 0, 4, 4'b0);
      do_reset();
      cyc(5);
      demand_in = 4'b0100;
      cyc(1);
      demand_in = 4'b0000;
      cyc(23);
      demand_in = 4'b0010;
      cyc(1);
      demand_in = 4'b0000;
      cyc(12);
      do_reset();
      cyc(12);

      chk("queue_drained", tk, 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
